// File: rtl/pkt_arb_if.sv
// pkt_arb_if: two-port packet input bus plus one output bus for the pkt_arb
// arbiter. The slave modport is the arbiter side; master is the upstream
// writers and downstream consumer side.
interface pkt_arb_if #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8
);
  logic [DATA_WIDTH-1:0] in0_data;
  logic [CTRL_WIDTH-1:0] in0_ctrl;
  logic                  in0_wr;
  logic                  in0_rdy;
  logic [DATA_WIDTH-1:0] in1_data;
  logic [CTRL_WIDTH-1:0] in1_ctrl;
  logic                  in1_wr;
  logic                  in1_rdy;
  logic [DATA_WIDTH-1:0] out_data;
  logic [CTRL_WIDTH-1:0] out_ctrl;
  logic                  out_wr;
  logic                  out_rdy;

  modport master (
    output in0_data, in0_ctrl, in0_wr, in1_data, in1_ctrl, in1_wr, out_rdy,
    input  in0_rdy, in1_rdy, out_data, out_ctrl, out_wr
  );

  modport slave (
    input  in0_data, in0_ctrl, in0_wr, in1_data, in1_ctrl, in1_wr, out_rdy,
    output in0_rdy, in1_rdy, out_data, out_ctrl, out_wr
  );
endinterface

// File: rtl/pkt_arb.sv
// pkt_arb: two-input packet arbiter. Each input has a 4-deep fall-through
// FIFO; a three-state FSM (IDLE/HDR/BODY) grants one port for a whole packet
// and forwards its words with zero latency from the FIFO head.
// Optional build macro: PKT_ARB_STRICT_PRIO_EN -- when defined, port 0 always
// wins a tie in IDLE; otherwise ties are resolved round-robin.
module pkt_arb #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8
) (
  input  logic       clk,
  input  logic       reset,
  pkt_arb_if.slave   bus,
  output logic       pkt_done0,
  output logic       pkt_done1,
  output logic [1:0] arb_state,
  output logic       arb_grant
);

  localparam logic [2:0] FULL_CNT = 3'd4;
  localparam logic [2:0] NEAR_CNT = 3'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    BODY = 2'd2
  } state_t;

  logic [DATA_WIDTH-1:0] fifo_data [2][4];
  logic [CTRL_WIDTH-1:0] fifo_ctrl [2][4];
  logic [1:0]            wr_ptr    [2];
  logic [1:0]            rd_ptr    [2];
  logic [2:0]            cnt       [2];

  logic [1:0] req;
  logic [1:0] push;
  logic [1:0] pop;
  logic [1:0] done;

  state_t state, state_nxt;
  logic   grant, grant_nxt;
  logic   last_grant, last_grant_nxt;
  logic   xfer;

  logic [DATA_WIDTH-1:0] head_data;
  logic [CTRL_WIDTH-1:0] head_ctrl;

  assign req = {cnt[1] != 3'd0, cnt[0] != 3'd0};

  // A write lands unless the FIFO is full; a same-cycle pop frees the slot.
  assign push = {bus.in1_wr && ((cnt[1] != FULL_CNT) || pop[1]),
                 bus.in0_wr && ((cnt[0] != FULL_CNT) || pop[0])};

  // FIFO storage: data is not reset, only pointers/occupancy are.
  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (push[p]) begin
        fifo_data[p][wr_ptr[p]] <= (p == 0) ? bus.in0_data : bus.in1_data;
        fifo_ctrl[p][wr_ptr[p]] <= (p == 0) ? bus.in0_ctrl : bus.in1_ctrl;
      end
    end
  end

  // FIFO pointers and occupancy; push and pop in one cycle both apply.
  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (!reset) begin
        wr_ptr[p] <= '0;
        rd_ptr[p] <= '0;
        cnt[p]    <= '0;
      end else begin
        if (push[p]) wr_ptr[p] <= wr_ptr[p] + 2'd1;
        if (pop[p])  rd_ptr[p] <= rd_ptr[p] + 2'd1;
        if (push[p] && !pop[p])      cnt[p] <= cnt[p] + 3'd1;
        else if (!push[p] && pop[p]) cnt[p] <= cnt[p] - 3'd1;
      end
    end
  end

  // Head word of the currently granted FIFO (fall-through view).
  always_comb begin
    head_data = fifo_data[grant][rd_ptr[grant]];
    head_ctrl = fifo_ctrl[grant][rd_ptr[grant]];
  end

  // Arbiter state, grant and round-robin history registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  // Next-state, grant selection and transfer/pop/done decode.
  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    xfer           = 1'b0;
    pop            = 2'b00;
    done           = 2'b00;
    case (state)
      IDLE: begin
        if (req != 2'b00) begin
          if (req == 2'b11) begin
`ifdef PKT_ARB_STRICT_PRIO_EN
            grant_nxt = 1'b0;
`else
            grant_nxt = ~last_grant;
`endif
          end else begin
            grant_nxt = req[1];
          end
          last_grant_nxt = grant_nxt;
          state_nxt      = HDR;
        end
      end
      HDR: begin
        if (bus.out_rdy && req[grant]) begin
          xfer       = 1'b1;
          pop[grant] = 1'b1;
          if (head_ctrl == '0) state_nxt = BODY;
        end
      end
      BODY: begin
        if (bus.out_rdy && req[grant]) begin
          xfer       = 1'b1;
          pop[grant] = 1'b1;
          if (head_ctrl != '0) begin
            done[grant] = 1'b1;
            state_nxt   = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.in0_rdy  = cnt[0] < NEAR_CNT;
  assign bus.in1_rdy  = cnt[1] < NEAR_CNT;
  assign bus.out_wr   = xfer;
  assign bus.out_data = xfer ? head_data : '0;
  assign bus.out_ctrl = xfer ? head_ctrl : '0;
  assign pkt_done0    = done[0];
  assign pkt_done1    = done[1];
  assign arb_state    = state;
  assign arb_grant    = grant;

endmodule

// File: tb/tb_pkt_arb.sv
// tb_pkt_arb: directed bench for pkt_arb with an ordered expected-word queue.
module tb_pkt_arb;
  localparam int DW = 64;
  localparam int CW = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       pkt_done0, pkt_done1, arb_grant;
  logic [1:0] arb_state;

  always #5 clk = ~clk;

  pkt_arb_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) bus ();

  pkt_arb #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .pkt_done0 (pkt_done0),
    .pkt_done1 (pkt_done1),
    .arb_state (arb_state),
    .arb_grant (arb_grant)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [CW-1:0] ctrl;
    logic          port;
    logic          last;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   nwr    = 0;
  bit   toggle_rdy = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void expect_w(input logic port, input logic [DW-1:0] d,
                                   input logic [CW-1:0] c, input logic last);
    exp_t e;
    e.data = d;
    e.ctrl = c;
    e.port = port;
    e.last = last;
    exp_q.push_back(e);
  endfunction

  task automatic monitor();
    exp_t e;
    if (bus.out_wr === 1'b1) begin
      nwr++;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_word observed=0x%0h expected=none", bus.out_data);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("out_data", 64'(bus.out_data), 64'(e.data));
        chk("out_ctrl", 64'(bus.out_ctrl), 64'(e.ctrl));
        chk("arb_grant", 64'(arb_grant), 64'(e.port));
        chk("pkt_done0", 64'(pkt_done0), 64'(e.last && !e.port));
        chk("pkt_done1", 64'(pkt_done1), 64'(e.last && e.port));
      end
    end else begin
      chk("out_wr", 64'(bus.out_wr), 64'd0);
      chk("idle_data", 64'(bus.out_data), 64'd0);
      chk("idle_ctrl_done", 64'({pkt_done1, pkt_done0, bus.out_ctrl}), 64'd0);
    end
  endtask

  // One clock: inputs already driven, sample mid-cycle, advance past the edge.
  task automatic step();
    if (toggle_rdy) bus.out_rdy = ~bus.out_rdy;
    #2;
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic put_raw(input logic port, input logic [DW-1:0] d, input logic [CW-1:0] c);
    if (port) begin
      bus.in1_wr = 1'b1; bus.in1_data = d; bus.in1_ctrl = c;
    end else begin
      bus.in0_wr = 1'b1; bus.in0_data = d; bus.in0_ctrl = c;
    end
    step();
    bus.in0_wr = 1'b0;
    bus.in1_wr = 1'b0;
  endtask

  task automatic put(input logic port, input logic [DW-1:0] d, input logic [CW-1:0] c);
    int n = 0;
    while ((port ? bus.in1_rdy : bus.in0_rdy) !== 1'b1) begin
      step();
      n++;
      if (n > 50) begin
        checks++;
        errors++;
        $error("FAIL rdy_timeout observed=0 expected=1");
        return;
      end
    end
    put_raw(port, d, c);
  endtask

  task automatic put_both(input logic [DW-1:0] d0, input logic [CW-1:0] c0,
                          input logic [DW-1:0] d1, input logic [CW-1:0] c1);
    bus.in0_wr = 1'b1; bus.in0_data = d0; bus.in0_ctrl = c0;
    bus.in1_wr = 1'b1; bus.in1_data = d1; bus.in1_ctrl = c1;
    step();
    bus.in0_wr = 1'b0;
    bus.in1_wr = 1'b0;
  endtask

  task automatic wait_empty(input string tag, input int max);
    int n = 0;
    while (exp_q.size() != 0 && n < max) begin
      step();
      n++;
    end
    chk({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic drain(input string tag, input int max);
    wait_empty(tag, max);
    chk({tag, "_state_idle"}, 64'(arb_state), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w0;
    reset       = 1'b0;
    bus.in0_wr  = 1'b0; bus.in0_data = '0; bus.in0_ctrl = '0;
    bus.in1_wr  = 1'b0; bus.in1_data = '0; bus.in1_ctrl = '0;
    bus.out_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // reset values
    chk("rst_out_wr", 64'(bus.out_wr), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_out_ctrl", 64'(bus.out_ctrl), 64'd0);
    chk("rst_done", 64'({pkt_done1, pkt_done0}), 64'd0);
    chk("rst_state", 64'(arb_state), 64'd0);
    chk("rst_grant", 64'(arb_grant), 64'd0);
    chk("rst_rdy", 64'({bus.in1_rdy, bus.in0_rdy}), 64'd3);
    reset = 1'b1;

    // simultaneous packets on both ports, arbitration order
    expect_w(0, 64'hA0, 8'h00, 0); expect_w(0, 64'hA1, 8'hff, 1);
`ifdef PKT_ARB_STRICT_PRIO_EN
    expect_w(0, 64'hB0, 8'h00, 0); expect_w(0, 64'hB1, 8'hff, 1);
    expect_w(1, 64'hC0, 8'h00, 0); expect_w(1, 64'hC1, 8'hff, 1);
`else
    expect_w(1, 64'hC0, 8'h00, 0); expect_w(1, 64'hC1, 8'hff, 1);
    expect_w(0, 64'hB0, 8'h00, 0); expect_w(0, 64'hB1, 8'hff, 1);
`endif
    expect_w(1, 64'hD0, 8'h00, 0); expect_w(1, 64'hD1, 8'hff, 1);
    put_both(64'hA0, 8'h00, 64'hC0, 8'h00);
    put_both(64'hA1, 8'hff, 64'hC1, 8'hff);
    put_both(64'hB0, 8'h00, 64'hD0, 8'h00);
    put_both(64'hB1, 8'hff, 64'hD1, 8'hff);
    chk("full_rdy", 64'({bus.in1_rdy, bus.in0_rdy}), 64'd0);
    bus.out_rdy = 1'b1;
    drain("two_port", 60);

    // single port-1 packet with the IDLE bubble
    w0 = nwr;
    expect_w(1, 64'h1111_0000, 8'hff, 0);
    expect_w(1, 64'h1111_0001, 8'h00, 0);
    expect_w(1, 64'h1111_0002, 8'h00, 0);
    expect_w(1, 64'h1111_0003, 8'h00, 0);
    expect_w(1, 64'h1111_0004, 8'hff, 1);
    put(1, 64'h1111_0000, 8'hff);
    chk("bubble_state", 64'(arb_state), 64'd0);
    chk("bubble_wr", 64'(bus.out_wr), 64'd0);
    put(1, 64'h1111_0001, 8'h00);
    put(1, 64'h1111_0002, 8'h00);
    put(1, 64'h1111_0003, 8'h00);
    put(1, 64'h1111_0004, 8'hff);
    drain("single", 30);
    chk("single_count", 64'(nwr - w0), 64'd5);

    // out_rdy toggling every cycle during a 6-word packet
    w0 = nwr;
    toggle_rdy = 1'b1;
    expect_w(0, 64'h2222_0000, 8'hff, 0);
    for (int i = 1; i < 5; i++) expect_w(0, 64'h2222_0000 + 64'(i), 8'h00, 0);
    expect_w(0, 64'h2222_0005, 8'h81, 1);
    put(0, 64'h2222_0000, 8'hff);
    for (int i = 1; i < 5; i++) put(0, 64'h2222_0000 + 64'(i), 8'h00);
    put(0, 64'h2222_0005, 8'h81);
    drain("toggle", 60);
    toggle_rdy  = 1'b0;
    bus.out_rdy = 1'b1;
    chk("toggle_count", 64'(nwr - w0), 64'd6);

    // port 0 underruns mid-packet while port 1 holds a full packet
    expect_w(0, 64'h3333_0000, 8'hff, 0);
    expect_w(0, 64'h3333_0001, 8'h00, 0);
    expect_w(0, 64'h3333_0002, 8'hff, 1);
    expect_w(1, 64'h4444_0000, 8'hff, 0);
    expect_w(1, 64'h4444_0001, 8'h00, 0);
    expect_w(1, 64'h4444_0002, 8'h00, 0);
    expect_w(1, 64'h4444_0003, 8'hff, 1);
    put(0, 64'h3333_0000, 8'hff);
    put(0, 64'h3333_0001, 8'h00);
    put_raw(1, 64'h4444_0000, 8'hff);
    put_raw(1, 64'h4444_0001, 8'h00);
    put_raw(1, 64'h4444_0002, 8'h00);
    put_raw(1, 64'h4444_0003, 8'hff);
    repeat (3) step();
    chk("underrun_grant", 64'(arb_grant), 64'd0);
    put(0, 64'h3333_0002, 8'hff);
    drain("underrun", 40);

    // fill port 0 while the output is stalled
    w0 = nwr;
    bus.out_rdy = 1'b0;
    expect_w(0, 64'h5555_0000, 8'hff, 0);
    expect_w(0, 64'h5555_0001, 8'h00, 0);
    expect_w(0, 64'h5555_0002, 8'h00, 0);
    expect_w(0, 64'h5555_0003, 8'hff, 1);
    put_raw(0, 64'h5555_0000, 8'hff);
    chk("fill_rdy1", 64'(bus.in0_rdy), 64'd1);
    put_raw(0, 64'h5555_0001, 8'h00);
    chk("fill_rdy2", 64'(bus.in0_rdy), 64'd1);
    put_raw(0, 64'h5555_0002, 8'h00);
    chk("fill_rdy3", 64'(bus.in0_rdy), 64'd0);
    put_raw(0, 64'h5555_0003, 8'hff);
    chk("fill_rdy4", 64'(bus.in0_rdy), 64'd0);
    repeat (2) step();
    bus.out_rdy = 1'b1;
    drain("fill", 30);
    chk("fill_count", 64'(nwr - w0), 64'd4);

    // reset in the middle of a port-0 body
    expect_w(0, 64'h6666_0000, 8'hff, 0);
    expect_w(0, 64'h6666_0001, 8'h00, 0);
    put(0, 64'h6666_0000, 8'hff);
    put(0, 64'h6666_0001, 8'h00);
    wait_empty("midpkt", 20);
    chk("midpkt_body", 64'(arb_state), 64'd2);
    bus.out_rdy = 1'b0;
    put_raw(0, 64'h6666_0002, 8'h00);
    reset = 1'b0;
    step();
    bus.out_rdy = 1'b1;
    #1;
    chk("midrst_out_wr", 64'(bus.out_wr), 64'd0);
    chk("midrst_rdy0", 64'(bus.in0_rdy), 64'd1);
    chk("midrst_state", 64'(arb_state), 64'd0);
    chk("midrst_done0", 64'(pkt_done0), 64'd0);
    chk("midrst_grant", 64'(arb_grant), 64'd0);
    reset = 1'b1;
    repeat (4) step();
    chk("post_rst_state", 64'(arb_state), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
